// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the dot-product sequencer.
// Holds the field widths, the zero and special-exponent constants, the
// sequencer state encoding and a small helper that flags Inf/NaN encodings.
package fp16_pkg;

  localparam int FP16_W = 16;
  localparam int EXP_W  = 5;
  localparam int MANT_W = 10;

  localparam logic [FP16_W-1:0] FP16_ZERO   = 16'h0000;
  localparam logic [EXP_W-1:0]  EXP_SPECIAL = 5'b11111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // True when the exponent field is all ones (Inf or NaN).
  function automatic logic fp16_is_special(input logic [FP16_W-1:0] x);
    return x[FP16_W-2 -: EXP_W] == EXP_SPECIAL;
  endfunction

endpackage

// File: rtl/fp_dot_seq.sv
// FP16 dot-product sequencer.
// Accepts a pair of N_ELEM-element FP16 vectors, feeds one element pair per
// cycle to an external combinational multiplier, folds each product into a
// running sum through an external combinational adder, and presents the
// final sum on a valid/ready output. No floating-point arithmetic lives here.
//
// Ports:
//   clk_i, rst_i              clock (rising edge), synchronous active-high reset
//   in_valid_i / in_ready_o   operand handshake
//   vec_a_i, vec_b_i          packed operand vectors, element k at [16k+15:16k]
//   mul_a_o, mul_b_o, mul_p_i external multiplier operands and product
//   add_a_o, add_b_o, add_sum_i external adder operands (accumulator, product) and sum
//   out_valid_o / out_ready_i result handshake
//   out_data_o                FP16 dot product
//   ovf_o                     sticky flag: an all-ones exponent was seen in this job
module fp_dot_seq
  import fp16_pkg::*;
#(
  parameter int N_ELEM = 4,
  parameter int IDX_W  = $clog2(N_ELEM)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [FP16_W*N_ELEM-1:0]   vec_a_i,
  input  logic [FP16_W*N_ELEM-1:0]   vec_b_i,
  output logic [FP16_W-1:0]          mul_a_o,
  output logic [FP16_W-1:0]          mul_b_o,
  input  logic [FP16_W-1:0]          mul_p_i,
  output logic [FP16_W-1:0]          add_a_o,
  output logic [FP16_W-1:0]          add_b_o,
  input  logic [FP16_W-1:0]          add_sum_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [FP16_W-1:0]          out_data_o,
  output logic                       ovf_o
);

  state_t                     state_q, state_d;
  logic [FP16_W*N_ELEM-1:0]   vec_a_q, vec_b_q;
  logic [FP16_W-1:0]          acc_q;
  logic [IDX_W-1:0]           idx_q;
  logic                       ovf_q;
  logic                       last_elem;

  assign last_elem = (idx_q == IDX_W'(N_ELEM - 1));
  assign ovf_o     = ovf_q;

  // Next state and all handshake/datapath outputs. The arithmetic ports are
  // only driven in RUN so the external units see zeros when idle.
  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = FP16_ZERO;
    mul_a_o     = FP16_ZERO;
    mul_b_o     = FP16_ZERO;
    add_a_o     = FP16_ZERO;
    add_b_o     = FP16_ZERO;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_d = RUN;
      end
      RUN: begin
        mul_a_o = vec_a_q[int'(idx_q)*FP16_W +: FP16_W];
        mul_b_o = vec_b_q[int'(idx_q)*FP16_W +: FP16_W];
        add_a_o = acc_q;
        add_b_o = mul_p_i;
        if (last_elem) state_d = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        out_data_o  = acc_q;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Acceptance latches a private copy of the
  // operands so input changes during a job have no effect; the overflow flag
  // is cleared only here (or by reset) so it stays readable after the result
  // handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      vec_a_q <= '0;
      vec_b_q <= '0;
      acc_q   <= FP16_ZERO;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            vec_a_q <= vec_a_i;
            vec_b_q <= vec_b_i;
            acc_q   <= FP16_ZERO;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        RUN: begin
          acc_q <= add_sum_i;
          idx_q <= idx_q + IDX_W'(1);
          ovf_q <= ovf_q | fp16_is_special(mul_p_i) | fp16_is_special(add_sum_i);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_dot_seq.sv
// Self-checking bench for fp_dot_seq. Provides behavioural FP16 multiplier
// and adder units on the arithmetic ports, a job-level reference model that
// predicts every output on every cycle, and directed scenarios with
// hand-computed results.
module tb_fp_dot_seq;
  import fp16_pkg::*;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [16*N-1:0] vec_a, vec_b;
  logic [15:0]     mul_a, mul_b, mul_p;
  logic [15:0]     add_a, add_b, add_sum;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_data;
  logic            ovf;

  int tests_run    = 0;
  int tests_failed = 0;

  fp_dot_seq #(.N_ELEM(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .vec_a_i     (vec_a),
    .vec_b_i     (vec_b),
    .mul_a_o     (mul_a),
    .mul_b_o     (mul_b),
    .mul_p_i     (mul_p),
    .add_a_o     (add_a),
    .add_b_o     (add_b),
    .add_sum_i   (add_sum),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .ovf_o       (ovf)
  );

  always #5 clk = ~clk;

  // FP16 <-> real conversion; Inf/NaN map to a huge magnitude that converts
  // back to Inf, which is all the scenarios need.
  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    int  m;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 31)     v = 1.0e10;
    else if (e == 0) v = real'(m) * (2.0 ** (-24));
    else             v = real'(1024 + m) * (2.0 ** (e - 25));
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real  a;
    int   e;
    int   mi;
    logic s;
    s = (r < 0.0);
    a = s ? -r : r;
    if (a == 0.0) return {s, 15'h0000};
    if (a >= 65520.0) return {s, 15'h7C00};
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
    mi = $rtoi(a * 1024.0 + 0.5);
    if (mi >= 2048) begin mi = 1024; e++; end
    if (e >= 31) return {s, 15'h7C00};
    if (mi < 1024) return {s, 5'd0, mi[9:0]};
    return {s, e[4:0], mi[9:0]};
  endfunction

  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    return r2h(h2r(a) * h2r(b));
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    return r2h(h2r(a) + h2r(b));
  endfunction

  // Stand-ins for the parent's combinational multiplier and adder.
  always_comb mul_p   = fp_mul(mul_a, mul_b);
  always_comb add_sum = fp_add(add_a, add_b);

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Reference model: one job is the element-wise products summed in index
  // order through the adder; outputs follow from where the job stands in time.
  bit          check_en = 1'b0;
  bit          busy     = 1'b0;
  bit          ovf_seen = 1'b0;
  int          cyc      = 0;
  int          accept_cyc = 0;
  int          chk_k;
  logic [15:0] m_a [N];
  logic [15:0] m_b [N];
  logic [15:0] m_partial [N];
  logic [15:0] m_res;
  bit          m_ovf;
  int          accept_log [$];

  function automatic void build_model(input logic [16*N-1:0] va, input logic [16*N-1:0] vb);
    logic [15:0] acc;
    logic [15:0] p;
    bit          o;
    acc = 16'h0000;
    o   = 1'b0;
    for (int j = 0; j < N; j++) begin
      m_a[j]       = va[16*j +: 16];
      m_b[j]       = vb[16*j +: 16];
      m_partial[j] = acc;
      p            = fp_mul(m_a[j], m_b[j]);
      acc          = fp_add(acc, p);
      o            = o | (p[14:10] == 5'b11111) | (acc[14:10] == 5'b11111);
    end
    m_res = acc;
    m_ovf = o;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (check_en) begin
      chk_k = cyc - accept_cyc;
      if (!busy) begin
        check("idle_ready", 16'(in_ready), 16'd1);
        check("idle_valid", 16'(out_valid), 16'd0);
        check("idle_data", out_data, 16'h0000);
        check("idle_ovf", 16'(ovf), 16'(ovf_seen));
        check("idle_mul_a", mul_a, 16'h0000);
        check("idle_add_b", add_b, 16'h0000);
      end else if (chk_k <= N) begin
        check("run_ready", 16'(in_ready), 16'd0);
        check("run_valid", 16'(out_valid), 16'd0);
        check("run_mul_a", mul_a, m_a[chk_k-1]);
        check("run_mul_b", mul_b, m_b[chk_k-1]);
        check("run_add_a", add_a, m_partial[chk_k-1]);
        check("run_add_b", add_b, fp_mul(m_a[chk_k-1], m_b[chk_k-1]));
      end else begin
        check("done_ready", 16'(in_ready), 16'd0);
        check("done_valid", 16'(out_valid), 16'd1);
        check("done_data", out_data, m_res);
        check("done_ovf", 16'(ovf), 16'(m_ovf));
        check("done_mul_a", mul_a, 16'h0000);
      end
      if (rst) begin
        busy     = 1'b0;
        ovf_seen = 1'b0;
      end else if (!busy) begin
        if (in_valid) begin
          busy       = 1'b1;
          accept_cyc = cyc;
          accept_log.push_back(cyc);
          build_model(vec_a, vec_b);
        end
      end else if (chk_k > N && out_ready) begin
        busy     = 1'b0;
        ovf_seen = m_ovf;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [16*N-1:0] a, input logic [16*N-1:0] b, input string name);
    vec_a    = a;
    vec_b    = b;
    in_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    check({name, "_accept"}, 16'(in_ready), 16'd1);
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input logic [15:0] exp_data, input logic exp_ovf,
                             input string name, output int waited);
    waited = 0;
    while (!out_valid && waited < 40) begin
      tick();
      waited++;
    end
    check({name, "_valid"}, 16'(out_valid), 16'd1);
    check({name, "_data"}, out_data, exp_data);
    check({name, "_ovf"}, 16'(ovf), 16'(exp_ovf));
  endtask

  localparam logic [16*N-1:0] VEC_BASIC_A = {16'h4200, 16'h3800, 16'h4000, 16'h3C00};
  localparam logic [16*N-1:0] VEC_ALL_TWO = {16'h4000, 16'h4000, 16'h4000, 16'h4000};
  localparam logic [16*N-1:0] VEC_SIGN_A  = {16'h3C00, 16'h3C00, 16'h3C00, 16'hBC00};
  localparam logic [16*N-1:0] VEC_ALL_ONE = {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
  localparam logic [16*N-1:0] VEC_INF_A   = {16'h3C00, 16'h3C00, 16'h3C00, 16'h7C00};

  initial begin
    int lat;
    int t;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    vec_a     = '0;
    vec_b     = '0;
    tick();
    tick();
    rst      = 1'b0;
    check_en = 1'b1;

    // Reset state
    check("rst_ready", 16'(in_ready), 16'd1);
    check("rst_valid", 16'(out_valid), 16'd0);
    check("rst_data", out_data, 16'h0000);
    check("rst_ovf", 16'(ovf), 16'd0);

    // Basic dot product: 1*2 + 2*2 + 0.5*2 + 3*2 = 13.0
    applyStimulus(VEC_BASIC_A, VEC_ALL_TWO, "basic");
    checkOutput(16'h4A80, 1'b0, "basic", lat);
    check("basic_latency", 16'(lat), 16'(N));
    tick();
    check("basic_ready_after", 16'(in_ready), 16'd1);

    // Sign handling: -1 + 1 + 1 + 1 = 2.0
    applyStimulus(VEC_SIGN_A, VEC_ALL_ONE, "sign");
    checkOutput(16'h4000, 1'b0, "sign", lat);
    tick();

    // Backpressure with ignored input activity in DONE
    out_ready = 1'b0;
    applyStimulus(VEC_BASIC_A, VEC_ALL_TWO, "bp");
    checkOutput(16'h4A80, 1'b0, "bp", lat);
    for (int i = 0; i < 5; i++) begin
      vec_a    = {$urandom, $urandom};
      in_valid = (i % 2 == 0);
      tick();
      check("bp_hold_ready", 16'(in_ready), 16'd0);
      check("bp_hold_valid", 16'(out_valid), 16'd1);
      check("bp_hold_data", out_data, 16'h4A80);
      check("bp_hold_ovf", 16'(ovf), 16'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_ready", 16'(in_ready), 16'd1);

    // Special exponent sets the sticky flag; the next finite job clears it
    applyStimulus(VEC_INF_A, VEC_ALL_ONE, "inf");
    checkOutput(16'h7C00, 1'b1, "inf", lat);
    tick();
    check("inf_ovf_sticky", 16'(ovf), 16'd1);
    applyStimulus(VEC_BASIC_A, VEC_ALL_TWO, "after_inf");
    checkOutput(16'h4A80, 1'b0, "after_inf", lat);
    tick();

    // Reset while index == 2
    applyStimulus(VEC_INF_A, VEC_ALL_ONE, "midrst");
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", 16'(in_ready), 16'd1);
    check("midrst_valid", 16'(out_valid), 16'd0);
    check("midrst_ovf", 16'(ovf), 16'd0);
    applyStimulus(VEC_BASIC_A, VEC_ALL_TWO, "post_rst");
    checkOutput(16'h4A80, 1'b0, "post_rst", lat);
    tick();

    // Back-to-back jobs with continuous valid and ready
    accept_log.delete();
    vec_a    = VEC_BASIC_A;
    vec_b    = VEC_ALL_TWO;
    in_valid = 1'b1;
    repeat (3 * (N + 2) + 2) tick();
    in_valid = 1'b0;
    t = 0;
    while (!in_ready && t < 40) begin
      tick();
      t++;
    end
    check("b2b_drain", 16'(in_ready), 16'd1);
    check("b2b_count_ge3", 16'(accept_log.size() >= 3), 16'd1);
    for (int i = 1; i < 3 && i < accept_log.size(); i++)
      check("b2b_spacing", 16'(accept_log[i] - accept_log[i-1]), 16'(N + 2));
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
